omega_network_scheduler: RTL and testbench



---
 rtl/omega_network_scheduler_pkg.sv | 25 ++
 rtl/omega_network_scheduler_if.sv | 30 +++
 rtl/omega_network_scheduler_rr_shift_picker.sv | 34 +++
 rtl/omega_network_scheduler.sv | 91 +++++++++
 tb/tb_omega_network_scheduler.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/omega_network_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// omega_network_scheduler_pkg : shared width helpers for the omega scheduler
// Revision: 1.0
// ============================================================================
package omega_network_scheduler_pkg;

  localparam int DEFAULT_IN_PORTS = 8;

  // Minimum of one bit so a 2-port network still has a control bit.
  function automatic int clog2_ports(input int n);
    int w;
    w = 1;
    for (int k = 1; k < 31; k++) begin
      if ((1 << k) < n) begin
        w = k + 1;
      end
    end
    return w;
  endfunction

  localparam int DEFAULT_ADDR_WIDTH = clog2_ports(DEFAULT_IN_PORTS);

endpackage
`default_nettype wire

// File: rtl/omega_network_scheduler_if.sv
`default_nettype none
// ============================================================================
// omega_network_scheduler_if : requester/network bundle around the scheduler
// Revision: 1.0
// ============================================================================
interface omega_network_scheduler_if
  import omega_network_scheduler_pkg::*;
#(
  parameter int IN_PORTS         = DEFAULT_IN_PORTS,
  parameter int ADDR_WIDTH_PORTS = clog2_ports(IN_PORTS)
);
  logic [0:IN_PORTS-1]                  req_valid;
  logic [IN_PORTS*ADDR_WIDTH_PORTS-1:0] req_dest;
  logic                                 stall;
  logic [0:IN_PORTS-1]                  push;
  logic [ADDR_WIDTH_PORTS-1:0]          control;
  logic [0:IN_PORTS-1]                  grant;
  logic                                 busy;

  modport master (
    output req_valid, req_dest, stall,
    input  push, control, grant, busy
  );

  modport slave (
    input  req_valid, req_dest, stall,
    output push, control, grant, busy
  );
endinterface
`default_nettype wire

// File: rtl/omega_network_scheduler_rr_shift_picker.sv
`default_nettype none
// ============================================================================
// rr_shift_picker : first set candidate at or after start, wrapping mod IN_PORTS
// Revision: 1.0
// ============================================================================
module rr_shift_picker
  import omega_network_scheduler_pkg::*;
#(
  parameter int IN_PORTS         = DEFAULT_IN_PORTS,
  parameter int ADDR_WIDTH_PORTS = clog2_ports(IN_PORTS)
) (
  input  logic [IN_PORTS-1:0]         candidates,
  input  logic [ADDR_WIDTH_PORTS-1:0] start,
  output logic [ADDR_WIDTH_PORTS-1:0] sel,
  output logic                        any_candidate
);

  logic [ADDR_WIDTH_PORTS-1:0] w_idx;

  always_comb begin
    sel           = '0;
    any_candidate = 1'b0;
    w_idx         = '0;
    for (int k = 0; k < IN_PORTS; k++) begin
      w_idx = start + ADDR_WIDTH_PORTS'(k);
      if (!any_candidate && candidates[w_idx]) begin
        sel           = w_idx;
        any_candidate = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/omega_network_scheduler.sv
`default_nettype none
// ============================================================================
// omega_network_scheduler : round-robin rotation-shift arbiter for omega_network_ff
// Revision: 1.0
// ============================================================================
module omega_network_scheduler
  import omega_network_scheduler_pkg::*;
#(
  parameter int IN_PORTS         = DEFAULT_IN_PORTS,
  parameter int ADDR_WIDTH_PORTS = clog2_ports(IN_PORTS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  omega_network_scheduler_if.slave  bus
);

  logic [0:IN_PORTS-1]         r_push;
  logic [ADDR_WIDTH_PORTS-1:0] r_control;
  logic [ADDR_WIDTH_PORTS-1:0] r_last_shift;
  logic                        r_busy;

  logic [0:IN_PORTS-1]         w_eff;
  logic [0:IN_PORTS-1]         w_issue;
  logic [ADDR_WIDTH_PORTS-1:0] w_need [IN_PORTS];
  logic [IN_PORTS-1:0]         w_cand;
  logic [ADDR_WIDTH_PORTS-1:0] w_start;
  logic [ADDR_WIDTH_PORTS-1:0] w_sel;
  logic                        w_any;

  // Port granted this cycle is masked so a one-cycle-late drop is not re-granted.
  assign w_eff   = bus.req_valid & ~r_push;
  assign w_start = r_last_shift + 1'b1;

  generate
    for (genvar g = 0; g < IN_PORTS; g++) begin : g_need
      assign w_need[g] = bus.req_dest[(g+1)*ADDR_WIDTH_PORTS-1 -: ADDR_WIDTH_PORTS]
                         - ADDR_WIDTH_PORTS'(g);
    end
  endgenerate

  always_comb begin
    w_cand = '0;
    for (int i = 0; i < IN_PORTS; i++) begin
      if (w_eff[i]) begin
        w_cand[w_need[i]] = 1'b1;
      end
    end
  end

  rr_shift_picker #(
    .IN_PORTS         (IN_PORTS),
    .ADDR_WIDTH_PORTS (ADDR_WIDTH_PORTS)
  ) u_picker (
    .candidates    (w_cand),
    .start         (w_start),
    .sel           (w_sel),
    .any_candidate (w_any)
  );

  always_comb begin
    w_issue = '0;
    for (int i = 0; i < IN_PORTS; i++) begin
      w_issue[i] = w_eff[i] && (w_need[i] == w_sel);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_push       <= '0;
      r_control    <= '0;
      r_last_shift <= '1;
      r_busy       <= 1'b0;
    end else begin
      r_busy <= |w_eff;
      if (!bus.stall && w_any) begin
        r_push       <= w_issue;
        r_control    <= w_sel;
        r_last_shift <= w_sel;
      end else begin
        r_push <= '0;
      end
    end
  end

  assign bus.push    = r_push;
  assign bus.grant   = r_push;
  assign bus.control = r_control;
  assign bus.busy    = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_omega_network_scheduler.sv
`default_nettype none
// ============================================================================
// tb_omega_network_scheduler : directed vector bench for omega_network_scheduler
// Revision: 1.0
// ============================================================================
module tb_omega_network_scheduler;

  logic clk;
  logic rst_n;

  omega_network_scheduler_if #(.IN_PORTS(8), .ADDR_WIDTH_PORTS(3)) bus ();

  omega_network_scheduler #(
    .IN_PORTS         (8),
    .ADDR_WIDTH_PORTS (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit          rst;
    logic [0:7]  valid;
    logic [23:0] dest;
    logic        stall;
    logic [0:7]  push;
    logic [2:0]  ctrl;
    logic        busy;
  } vec_t;

  vec_t vecs[13];

  function automatic logic [23:0] pd(input int d0, input int d1, input int d2, input int d3,
                                     input int d4, input int d5, input int d6, input int d7);
    logic [23:0] r;
    r = '0;
    r[2:0]   = 3'(d0);
    r[5:3]   = 3'(d1);
    r[8:6]   = 3'(d2);
    r[11:9]  = 3'(d3);
    r[14:12] = 3'(d4);
    r[17:15] = 3'(d5);
    r[20:18] = 3'(d6);
    r[23:21] = 3'(d7);
    return r;
  endfunction

  task automatic check_val(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [7:0] ep, input logic [2:0] ec,
                               input logic eb);
    check_val({tag, " push"}, bus.push, ep);
    check_val({tag, " grant"}, bus.grant, ep);
    check_val({tag, " control"}, {5'b0, bus.control}, {5'b0, ec});
    check_val({tag, " busy"}, {7'b0, bus.busy}, {7'b0, eb});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  int grants0;
  int grants1;

  initial begin
    // all-ports, drop after grant, test-3 sequence, wrap, late drop, round-robin
    vecs[0]  = '{0, 8'hFF,        pd(0,1,2,3,4,5,6,7), 0, 8'hFF,        3'd0, 1};
    vecs[1]  = '{0, 8'h00,        pd(0,1,2,3,4,5,6,7), 0, 8'h00,        3'd0, 0};
    vecs[2]  = '{1, 8'b1110_0000, pd(3,1,5,0,0,0,0,0), 0, 8'b0100_0000, 3'd0, 1};
    vecs[3]  = '{0, 8'b1010_0000, pd(3,1,5,0,0,0,0,0), 0, 8'b1010_0000, 3'd3, 1};
    vecs[4]  = '{0, 8'h00,        pd(3,1,5,0,0,0,0,0), 0, 8'h00,        3'd3, 0};
    vecs[5]  = '{0, 8'b0000_0001, pd(0,0,0,0,0,0,0,0), 0, 8'b0000_0001, 3'd1, 1};
    vecs[6]  = '{0, 8'h00,        pd(0,0,0,0,0,0,0,0), 0, 8'h00,        3'd1, 0};
    vecs[7]  = '{0, 8'hFF,        pd(0,1,2,3,4,5,6,7), 0, 8'hFF,        3'd0, 1};
    vecs[8]  = '{0, 8'hFF,        pd(0,1,2,3,4,5,6,7), 0, 8'h00,        3'd0, 0};
    vecs[9]  = '{0, 8'h00,        pd(0,1,2,3,4,5,6,7), 0, 8'h00,        3'd0, 0};
    vecs[10] = '{0, 8'b0001_0010, pd(0,0,0,5,0,0,6,0), 0, 8'b0001_0000, 3'd2, 1};
    vecs[11] = '{0, 8'b0000_0010, pd(0,0,0,5,0,0,6,0), 0, 8'b0000_0010, 3'd0, 1};
    vecs[12] = '{0, 8'h00,        pd(0,0,0,5,0,0,6,0), 0, 8'h00,        3'd0, 0};

    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_dest  = '0;
    bus.stall     = 1'b0;
    #12;
    check_outputs("reset", 8'h00, 3'd0, 1'b0);
    rst_n = 1'b1;
    tick();

    for (int v = 0; v < 13; v++) begin
      if (vecs[v].rst) pulse_reset();
      bus.req_valid = vecs[v].valid;
      bus.req_dest  = vecs[v].dest;
      bus.stall     = vecs[v].stall;
      tick();
      check_outputs($sformatf("vec%0d", v), vecs[v].push, vecs[v].ctrl, vecs[v].busy);
    end

    // stall holds off issue for three edges, then the request goes out
    pulse_reset();
    bus.req_valid = 8'b1000_0000;
    bus.req_dest  = pd(2,0,0,0,0,0,0,0);
    bus.stall     = 1'b1;
    for (int e = 0; e < 3; e++) begin
      tick();
      check_outputs($sformatf("stall%0d", e), 8'h00, 3'd0, 1'b1);
    end
    bus.stall = 1'b0;
    tick();
    check_outputs("stall_release", 8'b1000_0000, 3'd2, 1'b1);
    bus.req_valid = '0;
    tick();
    check_outputs("stall_drain", 8'h00, 3'd2, 1'b0);

    // two continuously re-requesting ports alternate shifts 0 and 1
    pulse_reset();
    bus.req_valid = 8'b1100_0000;
    bus.req_dest  = pd(0,2,0,0,0,0,0,0);
    grants0 = 0;
    grants1 = 0;
    for (int e = 0; e < 8; e++) begin
      tick();
      if (bus.grant[0]) grants0++;
      if (bus.grant[1]) grants1++;
      check_val($sformatf("alt%0d push", e), bus.push,
                (e % 2 == 0) ? 8'b1000_0000 : 8'b0100_0000);
      check_val($sformatf("alt%0d control", e), {5'b0, bus.control}, 8'((e % 2)));
    end
    check_val("alt grants port0", 8'(grants0), 8'd4);
    check_val("alt grants port1", 8'(grants1), 8'd4);

    // asynchronous reset mid-cycle while a word is being pushed
    bus.req_valid = 8'b0000_0001;
    bus.req_dest  = pd(0,0,0,0,0,0,0,0);
    tick();
    bus.req_valid = '0;
    tick();
    bus.req_valid = 8'b0000_0001;
    tick();
    check_outputs("pre_async", 8'b0000_0001, 3'd1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs("async_rst", 8'h00, 3'd0, 1'b0);
    bus.req_valid = '0;
    #10;
    rst_n = 1'b1;
    tick();
    check_outputs("post_rst", 8'h00, 3'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
